// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing generator.
//   Counts pixels (h_cnt) and lines (v_cnt) on every clk edge where pix_en=1,
//   and produces registered active-low syncs, video_on, and one-clk
//   line/frame ticks aligned with the counters.
// Ports:
//   clk        single clock domain
//   rst_n      async active-low reset
//   pix_en     pixel-rate enable, one pixel per clk edge where high
//   hsync      horizontal sync, active-low
//   vsync      vertical sync, active-low
//   video_on   high while (pixel_x, pixel_y) is in the visible area
//   pixel_x    current horizontal count
//   pixel_y    current vertical count
//   line_tick  one-clk pulse when h_cnt wraps to 0
//   frame_tick one-clk pulse when h_cnt and v_cnt both wrap to 0
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap, v_wrap;

  // Wrap on >= so any out-of-range count falls straight back to 0.
  always_comb begin
    h_wrap = (h_cnt >= H_MAX);
    v_wrap = h_wrap && (v_cnt >= V_MAX);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    if (v_wrap)      v_nxt = 10'd0;
    else if (h_wrap) v_nxt = v_cnt + 10'd1;
    else             v_nxt = v_cnt;
  end

  // Syncs and video_on are decoded from the next counts so the registered
  // outputs line up with pixel_x/pixel_y in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt      <= 10'd0;
      v_cnt      <= 10'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b1;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      if (pix_en) begin
        h_cnt      <= h_nxt;
        v_cnt      <= v_nxt;
        hsync      <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
        vsync      <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
        video_on   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_tick  <= h_wrap;
        frame_tick <= v_wrap;
      end
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit: system clock, the single clock domain (50 MHz board clock).
REQ-010 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-011 SHALL have port pix_en, input, 1 bit: pixel-rate enable from the frequency divider (25 MHz), sampled on rising clk.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-014 SHALL have port video_on, output, 1 bit: high while the current pixel is in the visible area.
REQ-015 SHALL have port pixel_x, output, 10 bits: current horizontal count (h_cnt).
REQ-016 SHALL have port pixel_y, output, 10 bits: current vertical count (v_cnt).
REQ-017 SHALL have port line_tick, output, 1 bit: one-clk pulse when h_cnt wraps to 0.
REQ-018 SHALL have port frame_tick, output, 1 bit: one-clk pulse when h_cnt and v_cnt both wrap to 0.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 SHALL hold h_cnt and v_cnt as 10-bit registers, with all counter and output state changing only on rising clk while pix_en=1.
REQ-021 SHALL hold all state when pix_en=0, except line_tick and frame_tick, which SHALL be 0 on every clk edge with pix_en=0.
REQ-022 SHALL, on pix_en=1, increment h_cnt if h_cnt < H_TOTAL-1, otherwise set h_cnt to 0 and pulse line_tick for exactly one clk.
REQ-023 SHALL advance v_cnt only on an h_cnt wrap: increment if v_cnt < V_TOTAL-1, otherwise set v_cnt to 0 and pulse frame_tick in the same clk as line_tick.
REQ-024 SHALL keep h_cnt within 0..H_TOTAL-1 and v_cnt within 0..V_TOTAL-1; unreachable counts SHALL not occur.
REQ-025 SHALL register hsync, vsync and video_on, decoded from the next counter values, so they are aligned with pixel_x/pixel_y in the same cycle with zero lag.
REQ-026 SHALL drive hsync=0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), otherwise 1.
REQ-027 SHALL drive vsync=0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), otherwise 1.
REQ-028 SHALL drive video_on=1 when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, otherwise 0.
REQ-029 SHALL drive pixel_x = h_cnt and pixel_y = v_cnt directly, including during blanking.
REQ-030 SHALL treat pix_en held high on consecutive clks as consecutive pixels, with no minimum spacing.

Reset
REQ-031 SHALL, while rst_n=0 and regardless of clk, force h_cnt=0, v_cnt=0, hsync=1, vsync=1, video_on=1, line_tick=0, frame_tick=0.
REQ-032 SHALL, on release of rst_n, have the first pix_en=1 edge move h_cnt to 1 with no tick.
REQ-033 SHALL, on reset asserted mid-frame, abandon the frame immediately with no partial sync pulse held.

Verification
REQ-034 SHALL be verified by: reset, then pix_en every 2nd clk for 800 ticks -> hsync low for exactly ticks 656..751 (96 ticks); line_tick once at the 800th tick; pixel_y=1 afterwards.
REQ-035 SHALL be verified by: a full frame of 420000 pix_en ticks -> vsync low for exactly 1600 ticks (lines 490-491); frame_tick exactly once, coincident with line_tick; counters at (0,0).
REQ-036 SHALL be verified by: counting video_on-high ticks over one frame -> exactly 307200; video_on=0 at (640,0) and at (0,480).
REQ-037 SHALL be verified by: pix_en held 0 for 1000 clks at (700,100) -> all outputs unchanged; line_tick=frame_tick=0 throughout.
REQ-038 SHALL be verified by: rst_n pulsed low at (700,491) between clk edges -> hsync=1, vsync=1, counters 0 immediately, without waiting for a clk edge.
REQ-039 SHALL be verified by: pix_en tied 1 for a full frame -> identical waveform compressed in time; frame period 420000 clks.
